// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB-Lite encodings and the slave state type used by the
//   on-chip RAM slave (ahb_ram_slave_p) and its bench.
//   No ports: constants, the FSM state enum and an alignment helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } ahb_state_t;

  // Low address bits that must be zero for a transfer of the given size.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (size)
      HSIZE_BYTE:  return 3'b000;
      HSIZE_HALF:  return 3'b001;
      HSIZE_WORD:  return 3'b011;
      HSIZE_DWORD: return 3'b111;
      default:     return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_ram_bemem.sv
// ahb_ram_bemem
//   Single-clock RAM, one write port with per-byte enables and one
//   synchronous read port. Read-first: a read and write to the same word
//   on the same edge returns the old contents. Contents are not reset.
// Ports:
//   clk    in   clock
//   we     in   DATA_W/8 byte write enables
//   waddr  in   write word index
//   wdata  in   write data
//   raddr  in   read word index
//   rdata  out  registered read data
module ahb_ram_bemem #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DATA_W/8-1:0]   we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2) - 1];

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
    for (int i = 0; i < NB; i++) begin
      if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/ahb_ram_slave_p.sv
// ahb_ram_slave_p
//   AHB-Lite slave in front of an on-chip byte-enabled RAM. Supports
//   pipelined back-to-back and burst transfers, run-time wait states, and
//   a two-cycle ERROR response for oversize, unaligned or out-of-range
//   accesses.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no data phase in progress; hready=1, OKAY
//   DATA  | data phase of a legal transfer; hready=0 while waits remain
//   ERR1  | first ERROR cycle; hready=0, ERROR
//   ERR2  | second ERROR cycle; hready=1, ERROR; may accept a new transfer
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   hsel, htrans, hsize  address-phase select, transfer type, size
//   hwrite, haddr        direction, byte address
//   hwdata               write data (data phase)
//   hready_in            bus HREADY qualifying the address phase
//   wait_cfg             wait states per OKAY data phase, sampled on accept
//   hrdata, hready, hresp  read data, data-phase ready, response
module ahb_ram_slave_p
  import ahb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 12,
  parameter int WAIT_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  input  logic              hready_in,
  input  logic [WAIT_W-1:0] wait_cfg,
  output logic [DATA_W-1:0] hrdata,
  output logic              hready,
  output logic [1:0]        hresp
);

  localparam int NB     = DATA_W / 8;
  localparam int ALSB   = $clog2(NB);
  localparam int IDX_HI = ALSB + DEPTH_LOG2;

  ahb_state_t state, state_nxt;

  logic [WAIT_W-1:0]     cnt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [NB-1:0]         lat_be;
  logic                  lat_write;

  logic                  fwd_hit;
  logic [NB-1:0]         fwd_be;
  logic [DATA_W-1:0]     fwd_data;

  logic [DATA_W-1:0]     hrdata_q;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     rd_word;

  logic                  accept, take, legal;
  logic                  size_err, align_err, range_err;
  logic                  commit, rd_phase;
  logic [DEPTH_LOG2-1:0] addr_idx, ram_raddr;
  logic [NB-1:0]         addr_be, ram_we;

  // Address-phase decode
  assign accept = hsel && hready_in &&
                  (htrans != HTRANS_IDLE) && (htrans != HTRANS_BUSY);

  assign size_err  = hsize > 3'(ALSB);
  assign align_err = |(haddr[2:0] & align_mask(hsize));
  assign range_err = |(haddr >> IDX_HI);
  assign legal     = !(size_err || align_err || range_err);
  assign addr_idx  = haddr[IDX_HI-1:ALSB];

  always_comb begin
    int off;
    int nbytes;
    off     = int'(haddr[ALSB-1:0]);
    nbytes  = 1 << hsize;
    addr_be = '0;
    for (int i = 0; i < NB; i++) begin
      addr_be[i] = (i >= off) && (i < off + nbytes);
    end
  end

  // hready depends only on registered state so the bus can loop it back
  // into hready_in without forming a combinational path.
  assign hready = !((state == ERR1) || ((state == DATA) && (cnt != '0)));
  assign take   = accept && hready;

  // Data phase
  assign commit   = (state == DATA) && (cnt == '0) && lat_write && !rst;
  assign rd_phase = (state == DATA) && !lat_write;
  assign ram_we   = commit ? lat_be : '0;

  // During waits the RAM keeps re-reading the latched word, so forwarding
  // only matters for the first data-phase cycle after a same-word write.
  assign ram_raddr = take ? addr_idx : lat_idx;

  always_comb begin
    rd_word = ram_rdata;
    for (int i = 0; i < NB; i++) begin
      if (fwd_hit && fwd_be[i]) rd_word[i*8 +: 8] = fwd_data[i*8 +: 8];
    end
  end

  assign hrdata = rd_phase ? rd_word : hrdata_q;

  ahb_ram_bemem #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .waddr (lat_idx),
    .wdata (hwdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hresp     = HRESP_OKAY;
    case (state)
      IDLE: begin
        if (take) state_nxt = legal ? DATA : ERR1;
      end
      DATA: begin
        if (cnt == '0) begin
          if (take) state_nxt = legal ? DATA : ERR1;
          else      state_nxt = IDLE;
        end
      end
      ERR1: begin
        hresp     = HRESP_ERROR;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp = HRESP_ERROR;
        if (take) state_nxt = legal ? DATA : ERR1;
        else      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer latch, wait counter, forwarding and read-data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_be    <= '0;
      lat_write <= 1'b0;
      fwd_hit   <= 1'b0;
      fwd_be    <= '0;
      fwd_data  <= '0;
      hrdata_q  <= '0;
    end else begin
      if (take) begin
        lat_idx   <= addr_idx;
        lat_be    <= addr_be;
        lat_write <= hwrite;
        cnt       <= legal ? wait_cfg : '0;
      end else if ((state == DATA) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end

      fwd_hit <= take && legal && !hwrite && commit && (addr_idx == lat_idx);
      if (commit) begin
        fwd_be   <= lat_be;
        fwd_data <= hwdata;
      end

      if (rd_phase) hrdata_q <= rd_word;
    end
  end

endmodule

// File: tb/tb_ahb_ram_slave_p.sv
module tb_ahb_ram_slave_p;
  import ahb_pkg::*;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BY = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic [2:0]  hsize = 3'd0;
  logic        hwrite = 1'b0;
  logic [15:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [3:0]  wait_cfg = '0;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ahb_ram_slave_p #(
    .DATA_W(32), .ADDR_W(16), .DEPTH_LOG2(12), .WAIT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata), .hready_in(hready),
    .wait_cfg(wait_cfg), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic [2:0]  sz;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wd;
    logic [3:0]  wc;
    logic        rdy;
    logic [1:0]  resp;
    logic        chk;
    logic [31:0] rd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sel, input logic [1:0] tr, input logic [2:0] sz,
                     input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [3:0] wc, input logic rdy, input logic [1:0] resp,
                     input logic chk, input logic [31:0] rd);
    vec_t v;
    v = '{sel, tr, sz, wr, addr, wd, wc, rdy, resp, chk, rd};
    vq.push_back(v);
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [2:0] sz,
                       input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [3:0] wc);
    hsel = sel; htrans = tr; hsize = sz; hwrite = wr;
    haddr = addr; hwdata = wd; wait_cfg = wc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int bwait[4];
  logic [31:0] bexp[4];

  initial begin
    int n;
    bwait[0] = 3; bwait[1] = 3; bwait[2] = 1; bwait[3] = 1;
    bexp[0] = 32'h1111_0000; bexp[1] = 32'h2222_0001;
    bexp[2] = 32'h3333_0002; bexp[3] = 32'h4444_0003;

    // sel tr sz wr addr wdata wcfg | rdy resp chk rdata
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'h0);          // reset state
    add(1,NS,2,1,16'h0010,32'h0,0,          1,2'b00,0,32'h0);
    add(1,NS,2,0,16'h0010,32'hDEADBEEF,0,   1,2'b00,0,32'h0);
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hDEADBEEF);   // forwarded
    add(1,NS,2,1,16'h0010,32'h0,0,          1,2'b00,1,32'hDEADBEEF);   // hold
    add(1,NS,0,1,16'h0013,32'h11223344,0,   1,2'b00,0,32'h0);
    add(1,NS,2,0,16'h0010,32'hAA556677,0,   1,2'b00,0,32'h0);
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hAA223344);   // merged forward
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hAA223344);
    add(1,NS,2,0,16'h0010,32'h0,0,          1,2'b00,0,32'h0);
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hAA223344);   // from RAM
    add(1,NS,2,1,16'h0014,32'h0,0,          1,2'b00,0,32'h0);
    add(1,NS,1,1,16'h0016,32'h01020304,0,   1,2'b00,0,32'h0);
    add(0,ID,0,0,16'h0000,32'hBEEFCAFE,0,   1,2'b00,0,32'h0);
    add(1,NS,2,0,16'h0014,32'h0,0,          1,2'b00,0,32'h0);
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hBEEF0304);
    add(1,NS,2,1,16'h0000,32'h0,0,          1,2'b00,0,32'h0);          // preload burst
    add(1,SQ,2,1,16'h0004,32'h11110000,0,   1,2'b00,0,32'h0);
    add(1,SQ,2,1,16'h0008,32'h22220001,0,   1,2'b00,0,32'h0);
    add(1,SQ,2,1,16'h000C,32'h33330002,0,   1,2'b00,0,32'h0);
    add(0,ID,0,0,16'h0000,32'h44440003,0,   1,2'b00,0,32'h0);
    add(1,NS,3,1,16'h0010,32'h0,0,          1,2'b00,0,32'h0);          // hsize=3
    add(0,ID,0,0,16'h0000,32'hFFFFFFFF,0,   0,2'b01,1,32'hBEEF0304);   // ERR1
    add(1,NS,1,0,16'h4002,32'hFFFFFFFF,0,   1,2'b01,0,32'h0);          // ERR2, range read
    add(0,ID,0,0,16'h0000,32'h0,0,          0,2'b01,0,32'h0);
    add(1,NS,1,1,16'h0011,32'h0,0,          1,2'b01,0,32'h0);          // unaligned half
    add(0,ID,0,0,16'h0000,32'hFFFFFFFF,0,   0,2'b01,0,32'h0);
    add(1,NS,2,1,16'h4000,32'h0,0,          1,2'b01,0,32'h0);          // alias of word 0
    add(0,ID,0,0,16'h0000,32'hFFFFFFFF,0,   0,2'b01,0,32'h0);
    add(1,NS,2,0,16'h0010,32'h0,0,          1,2'b01,0,32'h0);          // legal read from ERR2
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hAA223344);   // RAM unchanged
    add(1,BY,2,0,16'h0014,32'h0,0,          1,2'b00,0,32'h0);          // BUSY ignored
    add(0,ID,0,0,16'h0000,32'h0,0,          1,2'b00,1,32'hAA223344);

    drive(0,ID,0,0,16'h0,32'h0,0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].sel, vq[i].tr, vq[i].sz, vq[i].wr, vq[i].addr, vq[i].wd, vq[i].wc);
      @(negedge clk);
      check($sformatf("v%0d hready", i), 32'(hready), 32'(vq[i].rdy));
      check($sformatf("v%0d hresp", i), 32'(hresp), 32'(vq[i].resp));
      if (vq[i].chk) check($sformatf("v%0d hrdata", i), hrdata, vq[i].rd);
    end

    // 4-beat INCR read with waits; wait_cfg drops to 1 from beat 2 onwards
    @(posedge clk); #1 drive(1,NS,2,0,16'h0000,32'h0,4'd3);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (b < 3) drive(1,SQ,2,0,16'(4*(b+1)),32'h0,4'(bwait[b+1]));
      else       drive(0,ID,0,0,16'h0,32'h0,4'd0);
      n = 0;
      @(negedge clk);
      while (hready !== 1'b1 && n < 16) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("burst%0d waits", b), 32'(n), 32'(bwait[b]));
      check($sformatf("burst%0d hrdata", b), hrdata, bexp[b]);
      check($sformatf("burst%0d hresp", b), 32'(hresp), 32'(HRESP_OKAY));
    end

    // Reset during the commit cycle of a 2-wait write
    @(posedge clk); #1 drive(1,NS,2,1,16'h0020,32'h0,4'd0);
    @(posedge clk); #1 drive(0,ID,0,0,16'h0,32'h12345678,4'd0);
    @(posedge clk); #1 drive(1,NS,2,1,16'h0020,32'h0,4'd2);
    @(posedge clk); #1 drive(0,ID,0,0,16'h0,32'hCAFEF00D,4'd0);
    @(negedge clk); check("rstw d0 hready", 32'(hready), 32'h0);
    @(negedge clk); check("rstw d1 hready", 32'(hready), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); check("rstw d2 hready", 32'(hready), 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post-rst hready", 32'(hready), 32'h1);
    check("post-rst hresp", 32'(hresp), 32'h0);
    check("post-rst hrdata", hrdata, 32'h0);
    @(posedge clk); #1 drive(1,NS,2,0,16'h0020,32'h0,4'd0);
    @(posedge clk); #1 drive(0,ID,0,0,16'h0,32'h0,4'd0);
    @(negedge clk); check("rstw word kept", hrdata, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
